vreduce_unit: RTL and testbench

- Multi-cycle vector reduction stage directly downstream of the vector ALU.
- Consumes the five 32-bit lane results (VALUResultA..E) as one packed vector and folds them into a single 32-bit scalar: sum, signed max, signed min or xor.
- Processes one lane per cycle and drives scalar NZCV flags for the scalar writeback/flag path.
- Valid/ready handshake on both sides lets the control unit stall while a reduction is in flight.

---
 rtl/vreduce_unit_if.sv | 26 ++
 rtl/vreduce_unit.sv | 173 +++++++++++++++++
 tb/tb_vreduce_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vreduce_unit_if.sv
// Handshake bundle between the vector ALU side, the reduction unit and the
// scalar writeback consumer. Master drives the vector in and takes the scalar out.
interface vreduce_unit_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 5
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_lanes;
   logic [1:0]             red_op;
   logic [2:0]             vl;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_result;
   logic [3:0]             out_flags;

   modport master (
      output in_valid, in_lanes, red_op, vl, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_lanes, red_op, vl, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/vreduce_unit.sv
// Multi-cycle vector reduction: folds up to LANES lane results into one scalar
// (sum, signed max, signed min, xor), one lane per cycle, and produces NZCV.
module vreduce_unit #(
   parameter int WIDTH = 32,
   parameter int LANES = 5
) (
   input  logic          clk,
   input  logic          reset,
   vreduce_unit_if.slave bus
);
   // Lane index and lane count share the 3-bit width of the vl port.
   localparam int NSLOT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SUM  = 2'b00;
   localparam logic [1:0] OP_SMAX = 2'b01;
   localparam logic [1:0] OP_SMIN = 2'b10;

   state_t                 state_q, state_d;
   logic [LANES*WIDTH-1:0] lanes_q, lanes_d;
   logic [1:0]             op_q, op_d;
   logic [2:0]             vle_q, vle_d;
   logic [2:0]             idx_q, idx_d;
   logic [WIDTH-1:0]       acc_q, acc_d;
   logic                   c_q, c_d;
   logic                   v_q, v_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic [3:0]             flags_q, flags_d;

   logic [WIDTH-1:0]       lane_arr [NSLOT];
   logic [WIDTH-1:0]       cur_lane;
   logic [WIDTH-1:0]       lane0_in;
   logic [2:0]             vl_clamped;
   logic [WIDTH:0]         sum_w;
   logic                   sum_ovf;
   logic [WIDTH-1:0]       comb_acc;
   logic                   comb_c;
   logic                   comb_v;

   // Unpack the captured vector; unused slots read as zero so any idx is safe.
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_lane
         if (gi < LANES) begin : g_real
            assign lane_arr[gi] = lanes_q[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign lane_arr[gi] = '0;
         end
      end
   endgenerate

   assign cur_lane   = lane_arr[idx_q];
   assign lane0_in   = bus.in_lanes[WIDTH-1:0];
   assign vl_clamped = (bus.vl == 3'd0 || bus.vl > 3'(LANES)) ? 3'(LANES) : bus.vl;

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_result = result_q;
   assign bus.out_flags  = flags_q;

   // One fold step of the accumulator with the current lane, plus sticky C/V.
   always_comb begin
      sum_w    = {1'b0, acc_q} + {1'b0, cur_lane};
      sum_ovf  = (acc_q[WIDTH-1] == cur_lane[WIDTH-1]) &&
                 (sum_w[WIDTH-1] != acc_q[WIDTH-1]);
      comb_acc = acc_q;
      comb_c   = c_q;
      comb_v   = v_q;
      case (op_q)
         OP_SUM: begin
            comb_acc = sum_w[WIDTH-1:0];
            comb_c   = c_q | sum_w[WIDTH];
            comb_v   = v_q | sum_ovf;
         end
         OP_SMAX: begin
            if ($signed(cur_lane) > $signed(acc_q)) comb_acc = cur_lane;
         end
         OP_SMIN: begin
            if ($signed(cur_lane) < $signed(acc_q)) comb_acc = cur_lane;
         end
         default: begin
            comb_acc = acc_q ^ cur_lane;
         end
      endcase
   end

   // Next-state and datapath next values; result/flags only load on entry to DONE.
   always_comb begin
      state_d  = state_q;
      lanes_d  = lanes_q;
      op_d     = op_q;
      vle_d    = vle_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      c_d      = c_q;
      v_d      = v_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               lanes_d = bus.in_lanes;
               op_d    = bus.red_op;
               vle_d   = vl_clamped;
               acc_d   = lane0_in;
               idx_d   = 3'd1;
               c_d     = 1'b0;
               v_d     = 1'b0;
               if (vl_clamped == 3'd1) begin
                  state_d  = DONE;
                  result_d = lane0_in;
                  flags_d  = {lane0_in[WIDTH-1], (lane0_in == '0), 2'b00};
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            acc_d = comb_acc;
            c_d   = comb_c;
            v_d   = comb_v;
            idx_d = idx_q + 3'd1;
            if (idx_q == vle_q - 3'd1) begin
               state_d  = DONE;
               result_d = comb_acc;
               flags_d  = {comb_acc[WIDTH-1], (comb_acc == '0), comb_c, comb_v};
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers; reset clears everything so no partial result leaks out.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lanes_q  <= '0;
         op_q     <= '0;
         vle_q    <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         lanes_q  <= lanes_d;
         op_q     <= op_d;
         vle_q    <= vle_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         c_q      <= c_d;
         v_q      <= v_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end
endmodule

// File: tb/tb_vreduce_unit.sv
// Directed bench for vreduce_unit: a transaction-level model predicts the
// handshake and outputs every cycle, and each directed vector also carries
// hand-computed result, flags and latency.
module tb_vreduce_unit;
   localparam int W = 32;
   localparam int L = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vreduce_unit_if #(.WIDTH(W), .LANES(L)) bus ();
   vreduce_unit #(.WIDTH(W), .LANES(L)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [W*L-1:0] pack5(input logic [31:0] l0, l1, l2, l3, l4);
      return {l4, l3, l2, l1, l0};
   endfunction

   function automatic int eff_len(input logic [2:0] vl);
      return (vl == 3'd0 || int'(vl) > L) ? L : int'(vl);
   endfunction

   // Reduction computed with wide integer arithmetic: returns {N,Z,C,V,result}.
   function automatic logic [35:0] model_reduce(input logic [W*L-1:0] lanes,
                                                input logic [1:0] op, input logic [2:0] vl);
      int          n;
      logic [31:0] acc;
      logic [31:0] x;
      bit          c;
      bit          v;
      longint unsigned u;
      longint          s;
      n   = eff_len(vl);
      acc = lanes[31:0];
      c   = 0;
      v   = 0;
      for (int k = 1; k < n; k++) begin
         x = lanes[k*W +: W];
         case (op)
            2'b00: begin
               u = longint'({32'b0, acc}) + longint'({32'b0, x});
               s = longint'(int'(acc)) + longint'(int'(x));
               if (u > 64'h0000_0000_FFFF_FFFF) c = 1;
               if (s > 64'sd2147483647 || s < -64'sd2147483648) v = 1;
               acc = u[31:0];
            end
            2'b01:   if (int'(x) > int'(acc)) acc = x;
            2'b10:   if (int'(x) < int'(acc)) acc = x;
            default: acc = acc ^ x;
         endcase
      end
      return {acc[31], (acc == 32'd0), c, v, acc};
   endfunction

   // Transaction-level model: idle / busy for len-1 edges / holding a result.
   typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;
   mstate_t     m_st   = M_IDLE;
   int          m_cnt  = 0;
   bit          m_init = 0;
   logic [31:0] exp_res   = '0;
   logic [3:0]  exp_flags = '0;
   logic [35:0] m_pend;

   always @(posedge clk) begin
      if (!reset) begin
         m_st      = M_IDLE;
         exp_res   = '0;
         exp_flags = '0;
      end else begin
         case (m_st)
            M_IDLE: if (bus.in_valid) begin
               m_pend = model_reduce(bus.in_lanes, bus.red_op, bus.vl);
               m_cnt  = eff_len(bus.vl) - 1;
               if (m_cnt == 0) begin
                  m_st = M_DONE;
                  {exp_flags, exp_res} = m_pend;
               end else begin
                  m_st = M_BUSY;
               end
            end
            M_BUSY: begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_st = M_DONE;
                  {exp_flags, exp_res} = m_pend;
               end
            end
            default: if (bus.out_ready) m_st = M_IDLE;
         endcase
      end
      m_init = 1;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_init) begin
         check("cyc_in_ready", 64'(bus.in_ready), 64'(m_st == M_IDLE));
         check("cyc_out_valid", 64'(bus.out_valid), 64'(m_st == M_DONE));
         check("cyc_out_result", 64'(bus.out_result), 64'(exp_res));
         check("cyc_out_flags", 64'(bus.out_flags), 64'(exp_flags));
      end
   end

   // Present a vector for exactly the accept edge, then scramble the inputs.
   task automatic start(input logic [W*L-1:0] lanes, input logic [1:0] op, input logic [2:0] vl);
      bus.in_valid = 1'b1;
      bus.in_lanes = lanes;
      bus.red_op   = op;
      bus.vl       = vl;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_lanes = ~lanes;
      bus.red_op   = ~op;
      bus.vl       = 3'd2;
      @(negedge clk);
   endtask

   // Count edges after the accept edge until out_valid, bounded.
   task automatic wait_out(output int n);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic finish_out(input string name);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, "_back_idle"}, 64'(bus.in_ready), 64'd1);
   endtask

   task automatic do_op(input string name, input logic [W*L-1:0] lanes, input logic [1:0] op,
                        input logic [2:0] vl, input int exp_lat,
                        input logic [31:0] req_res, input logic [3:0] req_flags);
      int n;
      start(lanes, op, vl);
      check({name, "_in_ready_low"}, 64'(bus.in_ready), 64'(exp_lat == 0 ? 0 : 0));
      wait_out(n);
      check({name, "_latency"}, 64'(n), 64'(exp_lat));
      check({name, "_result"}, 64'(bus.out_result), 64'(req_res));
      check({name, "_flags"}, 64'(bus.out_flags), 64'(req_flags));
      $display("op %s: result=0x%08h flags=%04b latency=%0d", name, bus.out_result, bus.out_flags, n);
      finish_out(name);
   endtask

   initial begin
      int n;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_lanes  = '0;
      bus.red_op    = 2'b00;
      bus.vl        = 3'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_result", 64'(bus.out_result), 64'd0);
      check("reset_flags", 64'(bus.out_flags), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      do_op("sum5", pack5(1, 2, 3, 4, 5), 2'b00, 3'd5, 4, 32'd15, 4'b0000);
      do_op("sum_ovf", pack5(32'h7FFF_FFFF, 1, 9, 9, 9), 2'b00, 3'd2, 1, 32'h8000_0000, 4'b1001);
      do_op("sum_carry", pack5(32'hFFFF_FFFF, 1, 9, 9, 9), 2'b00, 3'd2, 1, 32'h0, 4'b0110);
      do_op("smax", pack5(32'hFFFF_FFFD, 7, 32'h8000_0000, 2, 7), 2'b01, 3'd5, 4, 32'd7, 4'b0000);
      do_op("smin", pack5(32'hFFFF_FFFD, 7, 32'h8000_0000, 2, 7), 2'b10, 3'd5, 4, 32'h8000_0000, 4'b1000);
      do_op("xor_vl0", pack5(32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678),
            2'b11, 3'd0, 4, 32'h0, 4'b0100);
      do_op("vl1", pack5(32'hABCD, 32'h1111, 32'h2222, 32'h3333, 32'h4444), 2'b00, 3'd1, 0, 32'hABCD, 4'b0000);
      do_op("sum_vl3", pack5(1, 2, 3, 100, 100), 2'b00, 3'd3, 2, 32'd6, 4'b0000);
      do_op("sum_vl6", pack5(1, 2, 3, 4, 5), 2'b00, 3'd6, 4, 32'd15, 4'b0000);

      // Backpressure: hold the result while new input is offered and refused.
      start(pack5(10, 20, 30, 40, 50), 2'b00, 3'd5);
      wait_out(n);
      check("bp_latency", 64'(n), 64'd4);
      bus.in_valid = 1'b1;
      bus.in_lanes = pack5(1, 2, 3, 0, 0);
      bus.red_op   = 2'b00;
      bus.vl       = 3'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_result", 64'(bus.out_result), 64'd150);
         check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      end
      $display("op bp_first: result=0x%08h flags=%04b", bus.out_result, bus.out_flags);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
      check("bp_idle_result_kept", 64'(bus.out_result), 64'd150);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      wait_out(n);
      check("bp_second_latency", 64'(n), 64'd2);
      check("bp_second_result", 64'(bus.out_result), 64'd6);
      $display("op bp_second: result=0x%08h flags=%04b latency=%0d", bus.out_result, bus.out_flags, n);
      finish_out("bp_second");

      // Reset after the second combine discards the operation.
      start(pack5(100, 200, 300, 400, 500), 2'b00, 3'd5);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_mid_result", 64'(bus.out_result), 64'd0);
      check("rst_mid_flags", 64'(bus.out_flags), 64'd0);
      $display("op rst_mid: result=0x%08h flags=%04b", bus.out_result, bus.out_flags);
      reset = 1'b1;
      @(negedge clk);
      do_op("sum_after_rst", pack5(1, 1, 1, 1, 1), 2'b00, 3'd5, 4, 32'd5, 4'b0000);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
